// File: rtl/opb_regbank_pkg.sv
// Shared types and helpers for the OPB register bank.
//   state_e      : two-state slave handshake (IDLE, ACK)
//   OPB_DW       : OPB data width
//   opb_to_user  : OPB [0:31] numbering -> user [31:0] numbering
//   user_to_opb  : inverse of opb_to_user
//   be_merge     : byte-enable merge of a new word into an old one (user order)
package opb_regbank_pkg;

    localparam int OPB_DW = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

    // User bit b carries OPB bit 31-b. OPB bit 0 is the MSB, so the numeric
    // value of the word is unchanged; only the index numbering flips.
    function automatic logic [OPB_DW-1:0] opb_to_user(input logic [0:OPB_DW-1] opb);
        logic [OPB_DW-1:0] u;
        for (int b = 0; b < OPB_DW; b++) begin
            u[b] = opb[OPB_DW-1-b];
        end
        return u;
    endfunction

    function automatic logic [0:OPB_DW-1] user_to_opb(input logic [OPB_DW-1:0] u);
        logic [0:OPB_DW-1] o;
        for (int b = 0; b < OPB_DW; b++) begin
            o[OPB_DW-1-b] = u[b];
        end
        return o;
    endfunction

    // BE[k] covers OPB bits [8k:8k+7], i.e. user bits [31-8k -: 8].
    function automatic logic [OPB_DW-1:0] be_merge(input logic [OPB_DW-1:0] old_w,
                                                   input logic [OPB_DW-1:0] new_w,
                                                   input logic [0:3]        be);
        logic [OPB_DW-1:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[OPB_DW-1-8*k -: 8] = new_w[OPB_DW-1-8*k -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave handshake: window decode, IDLE/ACK state machine, error latch.
//   clk, rst     : bus clock, async active-high reset
//   opb_abus     : byte address
//   opb_select   : transfer request
//   req_fire     : 1 in the IDLE cycle that accepts a transfer (commit point)
//   req_word     : word offset from C_BASEADDR (valid with req_fire)
//   sl_ack       : transfer acknowledge, one cycle
//   sl_err       : error acknowledge, only alongside sl_ack
module opb_slave_ack_fsm
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0100_6000,
    parameter logic [31:0] C_HIGHADDR = 32'h0100_60FF,
    parameter int          N_MAPPED   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:31] opb_abus,
    input  logic        opb_select,
    output logic        req_fire,
    output logic [29:0] req_word,
    output logic        sl_ack,
    output logic        sl_err
);

    state_e      state_q, state_d;
    logic        err_q, err_d;
    logic        hit;
    logic [31:0] offset;
    logic [1:0]  unused_byte_off;

    assign offset          = opb_abus - C_BASEADDR;
    assign unused_byte_off = offset[1:0];
    assign req_word        = offset[31:2];
    assign hit             = opb_select && (opb_abus >= C_BASEADDR) && (opb_abus <= C_HIGHADDR);
    assign req_fire        = (state_q == IDLE) && hit;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = ACK;
                    err_d   = (req_word >= 30'(N_MAPPED));
                end
            end
            ACK: begin
                // Always return to IDLE: a held select is re-serviced after one gap cycle.
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign sl_ack = (state_q == ACK);
    assign sl_err = (state_q == ACK) && err_q;

endmodule

// File: rtl/opb_register_bank.sv
// Parametrised OPB slave register bank: N_CTRL read/write control words,
// N_STAT read-only status words, optional shadow + atomic COMMIT.
//   OPB_Clk/OPB_Rst    : clock, async active-high reset
//   OPB_ABus/BE/DBus   : address, byte enables, write data (OPB [0:31] order)
//   OPB_RNW/select     : read flag, transfer request; OPB_seqAddr ignored
//   Sl_DBus/xferAck    : read data (zero outside ack), acknowledge
//   Sl_errAck          : unmapped word inside the window
//   Sl_retry/toutSup   : tied low
//   user_data_out      : live control words, word i at [32i+31:32i]
//   user_data_in       : status words, same packing
//   user_wr_strobe     : pulse when live word i takes a new value
//   commit_pulse       : pulse on an effective COMMIT write
module opb_register_bank
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR  = 32'h0100_6000,
    parameter logic [31:0] C_HIGHADDR  = 32'h0100_60FF,
    parameter int          N_CTRL      = 4,
    parameter int          N_STAT      = 2,
    parameter int          COMMIT_MODE = 0,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic                                    OPB_Clk,
    input  logic                                    OPB_Rst,
    input  logic [0:31]                             OPB_ABus,
    input  logic [0:3]                              OPB_BE,
    input  logic [0:31]                             OPB_DBus,
    input  logic                                    OPB_RNW,
    input  logic                                    OPB_select,
    input  logic                                    OPB_seqAddr,
    output logic [0:31]                             Sl_DBus,
    output logic                                    Sl_xferAck,
    output logic                                    Sl_errAck,
    output logic                                    Sl_retry,
    output logic                                    Sl_toutSup,
    output logic [N_CTRL*32-1:0]                    user_data_out,
    input  logic [(N_STAT > 0 ? N_STAT : 1)*32-1:0] user_data_in,
    output logic [N_CTRL-1:0]                       user_wr_strobe,
    output logic                                    commit_pulse
);

    localparam int          NS       = (N_STAT > 0) ? N_STAT : 1;
    localparam logic [29:0] W_COMMIT = 30'(N_CTRL + N_STAT);

    logic [N_CTRL-1:0][OPB_DW-1:0] live_q, live_d;
    logic [N_CTRL-1:0][OPB_DW-1:0] shadow_q, shadow_d;
    logic [N_CTRL-1:0]             strobe_q, strobe_d;
    logic                          commit_q, commit_d;
    logic [OPB_DW-1:0]             rdata_q, rdata_d;
    logic [NS-1:0][OPB_DW-1:0]     stat_w;
    logic [OPB_DW-1:0]             wdata;
    logic                          req_fire, sl_ack, sl_err;
    logic [29:0]                   req_word;
    logic                          unused_seq;

    assign unused_seq = OPB_seqAddr;
    assign stat_w     = user_data_in;
    assign wdata      = opb_to_user(OPB_DBus);

    opb_slave_ack_fsm #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR),
        .N_MAPPED   (N_CTRL + N_STAT + 1)
    ) u_fsm (
        .clk        (OPB_Clk),
        .rst        (OPB_Rst),
        .opb_abus   (OPB_ABus),
        .opb_select (OPB_select),
        .req_fire   (req_fire),
        .req_word   (req_word),
        .sl_ack     (sl_ack),
        .sl_err     (sl_err)
    );

    // Writes and read sampling happen on the IDLE->ACK edge, so the ACK cycle
    // only presents results; strobes/commit are registered into that cycle.
    always_comb begin
        live_d   = live_q;
        shadow_d = shadow_q;
        strobe_d = '0;
        commit_d = 1'b0;
        rdata_d  = rdata_q;
        if (req_fire) begin
            rdata_d = '0;
            if (OPB_RNW) begin
                for (int i = 0; i < N_CTRL; i++) begin
                    if (req_word == 30'(i))
                        rdata_d = (COMMIT_MODE != 0) ? shadow_q[i] : live_q[i];
                end
                for (int j = 0; j < N_STAT; j++) begin
                    if (req_word == 30'(N_CTRL + j)) rdata_d = stat_w[j];
                end
            end else begin
                for (int i = 0; i < N_CTRL; i++) begin
                    if (req_word == 30'(i)) begin
                        if (COMMIT_MODE != 0) begin
                            shadow_d[i] = be_merge(shadow_q[i], wdata, OPB_BE);
                        end else begin
                            live_d[i]   = be_merge(live_q[i], wdata, OPB_BE);
                            strobe_d[i] = 1'b1;
                        end
                    end
                end
                // COMMIT trigger is OPB bit 31 (user bit 0), in the byte BE[3] covers.
                if ((COMMIT_MODE != 0) && (req_word == W_COMMIT) && OPB_BE[3] && OPB_DBus[31]) begin
                    live_d   = shadow_q;
                    strobe_d = '1;
                    commit_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            live_q   <= {N_CTRL{RESET_VALUE}};
            shadow_q <= {N_CTRL{RESET_VALUE}};
            strobe_q <= '0;
            commit_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            live_q   <= live_d;
            shadow_q <= shadow_d;
            strobe_q <= strobe_d;
            commit_q <= commit_d;
            rdata_q  <= rdata_d;
        end
    end

    assign Sl_xferAck     = sl_ack;
    assign Sl_errAck      = sl_err;
    assign Sl_DBus        = sl_ack ? user_to_opb(rdata_q) : '0;
    assign Sl_retry       = 1'b0;
    assign Sl_toutSup     = 1'b0;
    assign user_data_out  = live_q;
    assign user_wr_strobe = strobe_q;
    assign commit_pulse   = commit_q;

endmodule

// File: tb/tb_opb_register_bank.sv
// Directed bench for opb_register_bank: one immediate-mode instance (u0)
// and one shadow/commit instance (u1) sharing the bus, separate selects.
module tb_opb_register_bank;

    logic         clk = 1'b0;
    logic         rst;
    logic [0:31]  abus, dbus;
    logic [0:3]   be;
    logic         rnw, sel0, sel1, seq;
    logic [63:0]  udi;

    logic [0:31]  dbus0, dbus1;
    logic         ack0, ack1, err0, err1, rty0, rty1, tos0, tos1;
    logic [127:0] uo0, uo1;
    logic [3:0]   stb0, stb1;
    logic         cmt0, cmt1;

    int tests = 0;
    int fails = 0;

    // Observations captured by xfer()
    logic         c_pre_ack, c_ack, c_err, c_post_ack, c_cmt;
    logic [31:0]  c_pre_rd, c_rd, c_post_rd;
    logic [3:0]   c_stb, c_post_stb;
    logic [127:0] c_pre_uo, c_uo;

    always #5 clk = ~clk;

    opb_register_bank #(.N_CTRL(4), .N_STAT(2), .COMMIT_MODE(0)) u0 (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel0), .OPB_seqAddr(seq),
        .Sl_DBus(dbus0), .Sl_xferAck(ack0), .Sl_errAck(err0), .Sl_retry(rty0), .Sl_toutSup(tos0),
        .user_data_out(uo0), .user_data_in(udi), .user_wr_strobe(stb0), .commit_pulse(cmt0)
    );

    opb_register_bank #(.N_CTRL(4), .N_STAT(2), .COMMIT_MODE(1)) u1 (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel1), .OPB_seqAddr(seq),
        .Sl_DBus(dbus1), .Sl_xferAck(ack1), .Sl_errAck(err1), .Sl_retry(rty1), .Sl_toutSup(tos1),
        .user_data_out(uo1), .user_data_in(udi), .user_wr_strobe(stb1), .commit_pulse(cmt1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transfer: select driven just after edge e0, ack expected after e1,
    // select dropped after e1, post-ack state sampled after e2.
    task automatic xfer(input bit which, input logic [31:0] addr, input bit rd,
                        input logic [3:0] b, input logic [31:0] d);
        @(posedge clk); #1;
        abus = addr; rnw = rd; be = b; dbus = d;
        if (which) sel1 = 1'b1; else sel0 = 1'b1;
        @(negedge clk);
        c_pre_ack = which ? ack1 : ack0;
        c_pre_rd  = which ? dbus1 : dbus0;
        c_pre_uo  = which ? uo1 : uo0;
        @(posedge clk); #1;
        c_ack = which ? ack1 : ack0;
        c_err = which ? err1 : err0;
        c_rd  = which ? dbus1 : dbus0;
        c_stb = which ? stb1 : stb0;
        c_cmt = which ? cmt1 : cmt0;
        c_uo  = which ? uo1 : uo0;
        sel0 = 1'b0; sel1 = 1'b0;
        @(posedge clk); #1;
        c_post_ack = which ? ack1 : ack0;
        c_post_rd  = which ? dbus1 : dbus0;
        c_post_stb = which ? stb1 : stb0;
    endtask

    initial begin
        int n;
        logic [5:0] pat;
        rst = 1'b1; sel0 = 1'b0; sel1 = 1'b0; abus = '0; dbus = '0; be = '0;
        rnw = 1'b1; seq = 1'b0; udi = '0;
        repeat (3) @(posedge clk); #1;

        // Reset state
        chk("rst_ack0", ack0, 0);
        chk("rst_dbus0", dbus0, 0);
        chk("rst_uo0", uo0, 0);
        chk("rst_uo1", uo1, 0);
        chk("rst_stb0", stb0, 0);
        chk("rst_tied", {rty0, tos0, rty1, tos1}, 0);
        rst = 1'b0;

        // Full write to word 1; OPB 0xDEADBEEF appears as the same numeric user value
        xfer(0, 32'h0100_6004, 0, 4'hF, 32'hDEAD_BEEF);
        chk("t1_pre_ack", c_pre_ack, 0);
        chk("t1_ack", c_ack, 1);
        chk("t1_err", c_err, 0);
        chk("t1_stb", c_stb, 4'b0010);
        chk("t1_uo", c_uo[63:32], 32'hDEAD_BEEF);
        chk("t1_post_ack", c_post_ack, 0);
        chk("t1_post_stb", c_post_stb, 0);

        // Partial write: only BE[1] (OPB bits 8:15)
        xfer(0, 32'h0100_6000, 0, 4'hF, 32'h1122_3344);
        xfer(0, 32'h0100_6000, 0, 4'b0100, 32'h00AB_0000);
        chk("t2_stb", c_stb, 4'b0001);
        xfer(0, 32'h0100_6000, 1, 4'hF, 32'h0);
        chk("t2_rd", c_rd, 32'h11AB_3344);
        chk("t2_rd_stb", c_stb, 0);
        chk("t2_uo", uo0[63:0], 64'hDEAD_BEEF_11AB_3344);

        // Shadow mode: writes land in shadows only
        for (int i = 0; i < 4; i++) xfer(1, 32'h0100_6000 + 4*i, 0, 4'hF, 32'hC0DE_0000 | i);
        chk("t3_live_hold", uo1, 0);
        chk("t3_wr_stb", c_stb, 0);
        xfer(1, 32'h0100_6008, 1, 4'hF, 32'h0);
        chk("t3_rd_shadow", c_rd, 32'hC0DE_0002);
        xfer(1, 32'h0100_6018, 0, 4'hF, 32'hFFFF_FFFE);
        chk("t3_nocommit_b31", {c_cmt, c_stb, c_uo}, 0);
        xfer(1, 32'h0100_6018, 0, 4'b1110, 32'h0000_0001);
        chk("t3_nocommit_be3", {c_cmt, c_stb, c_uo}, 0);
        xfer(1, 32'h0100_6018, 0, 4'hF, 32'h0000_0001);
        chk("t3_pre_uo", c_pre_uo, 0);
        chk("t3_uo", c_uo, 128'hC0DE_0003_C0DE_0002_C0DE_0001_C0DE_0000);
        chk("t3_cmt", c_cmt, 1);
        chk("t3_stb", c_stb, 4'b1111);
        chk("t3_post_stb", c_post_stb, 0);
        xfer(1, 32'h0100_6018, 1, 4'hF, 32'h0);
        chk("t3_commit_rd", {c_ack, c_err, c_rd}, {2'b10, 32'h0});
        xfer(0, 32'h0100_6018, 0, 4'hF, 32'h0000_0001);
        chk("t3_mode0_commit", {c_ack, c_err, c_cmt, c_stb}, 7'b1000000);

        // Status reads: data only in the ack cycle
        udi = {32'h1234_5678, 32'h0000_0ABC};
        xfer(0, 32'h0100_6010, 1, 4'hF, 32'h0);
        chk("t4_pre_rd", c_pre_rd, 0);
        chk("t4_rd", c_rd, 32'h0000_0ABC);
        chk("t4_post_rd", c_post_rd, 0);
        xfer(0, 32'h0100_6014, 1, 4'hF, 32'h0);
        chk("t4_rd1", c_rd, 32'h1234_5678);
        xfer(0, 32'h0100_6010, 0, 4'hF, 32'hFFFF_FFFF);
        chk("t4_stat_wr", {c_ack, c_err, c_stb}, 6'b100000);
        chk("t4_stat_wr_uo", uo0[63:0], 64'hDEAD_BEEF_11AB_3344);

        // Unmapped word inside window, then outside window
        xfer(0, 32'h0100_60F0, 1, 4'hF, 32'h0);
        chk("t5_unmapped", {c_ack, c_err, c_rd}, {2'b11, 32'h0});
        xfer(0, 32'h0100_601C, 0, 4'hF, 32'hFFFF_FFFF);
        chk("t5_unmapped_wr", {c_ack, c_err, c_stb}, 6'b110000);
        chk("t5_unmapped_uo", uo0, {32'h0, 32'h0, 64'hDEAD_BEEF_11AB_3344});
        @(posedge clk); #1;
        abus = 32'h0100_7000; rnw = 1'b1; sel0 = 1'b1;
        n = 0;
        repeat (16) begin
            @(posedge clk); #1;
            if (ack0) n++;
        end
        sel0 = 1'b0;
        chk("t5_outside", n, 0);

        // Held select: serviced every other cycle
        @(posedge clk); #1;
        abus = 32'h0100_6004; rnw = 1'b1; sel0 = 1'b1;
        pat = '0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            pat[k] = ack0;
        end
        sel0 = 1'b0;
        chk("burst_pattern", pat, 6'b010101);

        // Reset during the ack cycle
        @(posedge clk); #1;
        abus = 32'h0100_600C; rnw = 1'b0; be = 4'hF; dbus = 32'h0000_0055; sel0 = 1'b1;
        @(posedge clk); #1;
        chk("t6_ack_before_rst", {ack0, stb0, uo0[127:96]}, {1'b1, 4'b1000, 32'h0000_0055});
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_outputs", {ack0, err0, stb0, dbus0, uo0}, 0);
        sel0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        xfer(0, 32'h0100_600C, 1, 4'hF, 32'h0);
        chk("t6_after_rd", {c_ack, c_rd}, {1'b1, 32'h0});
        xfer(0, 32'h0100_6004, 0, 4'hF, 32'hCAFE_F00D);
        chk("t6_after_wr", {c_ack, c_stb, uo0[63:32]}, {1'b1, 4'b0010, 32'hCAFE_F00D});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
